// File: rtl/clk_ctrl_pkg.sv
// Shared types for the clock-request gate controller.
package clk_ctrl_pkg;

  localparam int unsigned CLK_CTRL_STATE_W = 2;

  typedef enum logic [CLK_CTRL_STATE_W-1:0] {
    OFF       = 2'd0,
    WAKE      = 2'd1,
    ON        = 2'd2,
    IDLE_WAIT = 2'd3
  } clk_ctrl_state_e;

endpackage

// File: rtl/clk_req_gate_ctrl.sv
// Drives the enable of one hard clock-gate cell from NB_REQ req/ack requesters,
// with a settle delay before acking and an idle hysteresis before gating off.
module clk_req_gate_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned NB_REQ      = 4,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned IDLE_CYCLES = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [NB_REQ-1:0]           i_req,
  output logic [NB_REQ-1:0]           o_ack,
  input  logic                        i_force_on,
  output logic                        o_clk_en,
  output logic                        o_busy,
  output logic [CLK_CTRL_STATE_W-1:0] o_state
);

  localparam int unsigned CNT_MAX = (WAKE_CYCLES > IDLE_CYCLES) ? WAKE_CYCLES : IDLE_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  clk_ctrl_state_e   state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NB_REQ-1:0] ack_q, ack_d;
  logic              clk_en_q, clk_en_d;
  logic              busy_q, busy_d;
  logic              any_req;

  // Next-state and registered-output decode; one counter serves WAKE and IDLE_WAIT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    any_req = (|i_req) | i_force_on;

    case (state_q)
      OFF: begin
        if (any_req) begin
          if (WAKE_CYCLES == 0) begin
            state_d = ON;
          end else begin
            state_d = WAKE;
            cnt_d   = CNT_W'(WAKE_CYCLES);
          end
        end
      end
      WAKE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (any_req) begin
          state_d = ON;
        end else begin
          state_d = IDLE_WAIT;
          cnt_d   = CNT_W'(IDLE_CYCLES);
        end
      end
      ON: begin
        if (!any_req) begin
          if (IDLE_CYCLES == 0) begin
            state_d = OFF;
            cnt_d   = '0;
          end else begin
            state_d = IDLE_WAIT;
            cnt_d   = CNT_W'(IDLE_CYCLES);
          end
        end
      end
      IDLE_WAIT: begin
        // A request arriving as the counter expires still keeps the clock on.
        if (any_req) begin
          state_d = ON;
        end else if (cnt_q == '0) begin
          state_d = OFF;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = OFF;
        cnt_d   = '0;
      end
    endcase

    // Acks are granted only while settled in ON; a dropped req always clears its ack.
    if ((state_d == ON) && (state_q != OFF)) begin
      ack_d = i_req;
    end else begin
      ack_d = ack_q & i_req;
    end

    clk_en_d = (state_d != OFF);
    busy_d   = (state_d != OFF);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= OFF;
      cnt_q    <= '0;
      ack_q    <= '0;
      clk_en_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      clk_en_q <= clk_en_d;
      busy_q   <= busy_d;
    end
  end

  assign o_ack    = ack_q;
  assign o_clk_en = clk_en_q;
  assign o_busy   = busy_q;
  assign o_state  = state_q;

endmodule

// File: tb/tb_clk_req_gate_ctrl.sv
// Self-checking bench for clk_req_gate_ctrl: directed scenarios plus constrained
// random requester traffic, checked against a deadline-based reference model.
module tb_clk_req_gate_ctrl;

  localparam int unsigned NB_REQ      = 4;
  localparam int unsigned WAKE_CYCLES = 2;
  localparam int unsigned IDLE_CYCLES = 16;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic [NB_REQ-1:0] i_req;
  logic [NB_REQ-1:0] o_ack;
  logic              i_force_on;
  logic              o_clk_en;
  logic              o_busy;
  logic [1:0]        o_state;

  always #5 i_clk = ~i_clk;

  clk_req_gate_ctrl #(
    .NB_REQ      (NB_REQ),
    .WAKE_CYCLES (WAKE_CYCLES),
    .IDLE_CYCLES (IDLE_CYCLES)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_req      (i_req),
    .o_ack      (o_ack),
    .i_force_on (i_force_on),
    .o_clk_en   (o_clk_en),
    .o_busy     (o_busy),
    .o_state    (o_state)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: clock-on flag plus absolute edge deadlines for settling and switch-off.
  int                cyc = 0;
  bit                m_en;
  int                m_ready_at;
  bit                m_quiet;
  int                m_off_at;
  logic [NB_REQ-1:0] m_ack;

  function automatic void model_reset();
    m_en       = 1'b0;
    m_ready_at = 0;
    m_quiet    = 1'b0;
    m_off_at   = 0;
    m_ack      = '0;
  endfunction

  function automatic void model_edge();
    logic [NB_REQ-1:0] ack_n;
    bit                any;
    cyc++;
    if (!i_rst_n) begin
      model_reset();
      return;
    end
    any   = (|i_req) || i_force_on;
    ack_n = m_ack & i_req;
    if (!m_en) begin
      if (any) begin
        m_en       = 1'b1;
        m_ready_at = cyc + int'(WAKE_CYCLES) + 1;
        m_quiet    = 1'b0;
      end
    end else if (cyc >= m_ready_at) begin
      if (any) begin
        m_quiet = 1'b0;
        ack_n   = i_req;
      end else if (!m_quiet) begin
        m_quiet  = 1'b1;
        m_off_at = cyc + int'(IDLE_CYCLES) + 1;
        if (IDLE_CYCLES == 0 && (cyc > m_ready_at || WAKE_CYCLES == 0)) begin
          m_en    = 1'b0;
          m_quiet = 1'b0;
        end
      end else if (cyc == m_off_at) begin
        m_en    = 1'b0;
        m_quiet = 1'b0;
      end
    end
    m_ack = ack_n;
  endfunction

  function automatic int model_state();
    if (!m_en) return 0;
    if (WAKE_CYCLES > 0 && cyc < m_ready_at) return 1;
    if (m_quiet) return 3;
    return 2;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_all();
    check_eq("clk_en", 32'(o_clk_en), 32'(m_en));
    check_eq("ack",    32'(o_ack),    32'(m_ack));
    check_eq("busy",   32'(o_busy),   32'(m_en));
    check_eq("state",  32'(o_state),  32'(model_state()));
  endtask

  task automatic step();
    @(posedge i_clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  bit quiet_phase;

  initial begin
    i_rst_n    = 1'b0;
    i_req      = '0;
    i_force_on = 1'b0;
    model_reset();
    steps(3);
    check_eq("rst_state", 32'(o_state), 32'd0);
    i_rst_n = 1'b1;
    steps(2);

    // Single request: enable next edge, ack after the settle delay.
    i_req = 4'b0001;
    step();
    check_eq("t1_en", 32'(o_clk_en), 32'd1);
    steps(2);
    check_eq("t1_ack_early", 32'(o_ack[0]), 32'd0);
    step();
    check_eq("t1_ack", 32'(o_ack[0]), 32'd1);
    steps(3);

    // Drop all requests and ride out the idle hysteresis.
    i_req = '0;
    step();
    check_eq("t2_ack_drop", 32'(o_ack), 32'd0);
    steps(int'(IDLE_CYCLES) + 3);
    check_eq("t2_off", 32'(o_clk_en), 32'd0);

    // Re-request during IDLE_WAIT, at counter 5 and at counter 0.
    i_req = 4'b0001;
    steps(6);
    i_req = '0;
    for (int k = 0; k < 40 && !(m_quiet && (m_off_at - cyc == 6)); k++) step();
    check_eq("t3_in_idle", 32'(o_state), 32'd3);
    i_req = 4'b0100;
    step();
    check_eq("t3_ack2", 32'(o_ack[2]), 32'd1);
    check_eq("t3_en", 32'(o_clk_en), 32'd1);
    i_req = '0;
    for (int k = 0; k < 40 && !(m_quiet && (m_off_at == cyc + 1)); k++) step();
    check_eq("t3_in_idle0", 32'(o_state), 32'd3);
    i_req = 4'b0100;
    step();
    check_eq("t3_stay_on", 32'(o_clk_en), 32'd1);
    check_eq("t3_on", 32'(o_state), 32'd2);
    i_req = '0;
    steps(int'(IDLE_CYCLES) + 4);

    // Request withdrawn during WAKE is never acked.
    i_req = 4'b0010;
    step();
    i_req = '0;
    steps(int'(WAKE_CYCLES) + int'(IDLE_CYCLES) + 4);
    check_eq("t4_off", 32'(o_state), 32'd0);

    // Force-on keeps the clock up without acks.
    i_force_on = 1'b1;
    steps(40);
    check_eq("t5_no_ack", 32'(o_ack), 32'd0);
    i_force_on = 1'b0;
    steps(int'(IDLE_CYCLES) + 4);

    // Asynchronous reset while acks are high.
    i_req = 4'b0111;
    steps(6);
    check_eq("t6_acks", 32'(o_ack), 32'd7);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_eq("t6_rst_en", 32'(o_clk_en), 32'd0);
    check_eq("t6_rst_ack", 32'(o_ack), 32'd0);
    check_eq("t6_rst_state", 32'(o_state), 32'd0);
    model_reset();
    i_req = '0;
    steps(2);
    i_rst_n = 1'b1;
    steps(2);
    i_req = 4'b0001;
    step();
    check_eq("t6_restart", 32'(o_state), 32'd1);
    steps(5);
    i_req = '0;
    steps(int'(IDLE_CYCLES) + 4);

    // Random requester traffic obeying the handshake rule.
    for (int k = 0; k < 2000; k++) begin
      quiet_phase = ((k / 80) % 3) == 2;
      for (int i = 0; i < int'(NB_REQ); i++) begin
        if (quiet_phase) i_req[i] = 1'b0;
        else if (i_req[i]) begin
          if ($urandom_range(7) == 0) i_req[i] = 1'b0;
        end else if (!m_ack[i] && $urandom_range(5) == 0) begin
          i_req[i] = 1'b1;
        end
      end
      if (quiet_phase) i_force_on = 1'b0;
      else if ($urandom_range(40) == 0) i_force_on = ~i_force_on;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
